// File: rtl/centroid_update_block.sv
// centroid_update_block
// Recomputes the K k-means centroids after an accumulation pass: for each
// centroid it fetches coordinate sums, point count and the previous centroid,
// divides every sum by the count with seven parallel restoring dividers and
// writes the result to the pipe1 centroid registers. Empty centroids keep
// their previous value. Latency is fixed at 26 cycles per centroid.
//
// Build option: define CENT_UPDATE_ROUND_EN to round quotients half-up
// (dividend = sum + count/2); otherwise quotients are truncated.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | read strobe to accumulator storage for centroid k
// LOAD   | latch sums, count and old centroid; seed dividers
// DIV    | 23 cycles, one quotient bit per cycle, MSB first
// WRITE  | cent_wr pulse with new centroid k
// DONE   | one-cycle done pulse

module centroid_update_block #(
  parameter int CENTROID_NUM     = 8,
  parameter int COORD_NUM        = 7,
  parameter int ACCUM_CORD_WIDTH = 22,
  parameter int CORD_WIDTH       = 13,
  parameter int COUNT_WIDTH      = 10,
  parameter int ACCUM_WIDTH      = COORD_NUM * ACCUM_CORD_WIDTH,
  parameter int DATA_WIDTH       = COORD_NUM * CORD_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   acc_rd_en,
  output logic [2:0]             acc_rd_idx,
  input  logic [ACCUM_WIDTH-1:0] acc_data,
  input  logic [COUNT_WIDTH-1:0] acc_count,
  input  logic [DATA_WIDTH-1:0]  old_centroid,
  output logic [DATA_WIDTH-1:0]  new_centroid,
  output logic [2:0]             cent_cnt,
  output logic                   cent_wr,
  output logic                   busy,
  output logic                   done
);

  localparam int DVD_W = ACCUM_CORD_WIDTH + 1;
  localparam logic [4:0] DIV_LAST = 5'(DVD_W - 1);
  localparam logic [2:0] LAST_K = 3'(CENTROID_NUM - 1);
  localparam logic [DVD_W-1:0] SAT_MAX = DVD_W'((1 << CORD_WIDTH) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_DIV, S_WRITE, S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [2:0]                              r_k;
  logic [4:0]                              r_div_cnt;
  logic [COUNT_WIDTH-1:0]                  r_count;
  logic [DATA_WIDTH-1:0]                   r_old;
  logic [DATA_WIDTH-1:0]                   r_new;
  logic [2:0]                              r_cnt;
  logic [COORD_NUM-1:0][DVD_W-1:0]         r_dvd;
  logic [COORD_NUM-1:0][COUNT_WIDTH-1:0]   r_rem;
  logic [COORD_NUM-1:0][DVD_W-2:0]         r_quo;

  logic [COORD_NUM-1:0][DVD_W-1:0]         w_dvd_init;
  logic [COORD_NUM-1:0][DVD_W-1:0]         w_dvd_sh;
  logic [COORD_NUM-1:0][COUNT_WIDTH:0]     w_trial;
  logic [COORD_NUM-1:0][COUNT_WIDTH-1:0]   w_rem_nxt;
  logic [COORD_NUM-1:0][DVD_W-1:0]         w_quo_nxt;
  logic [DATA_WIDTH-1:0]                   w_sat;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; start outside IDLE is ignored
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_FETCH;
      S_FETCH: w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_DIV;
      S_DIV:   if (r_div_cnt == 5'd0) w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = (r_k == LAST_K) ? S_DONE : S_FETCH;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control outputs decoded from state
  always_comb begin
    acc_rd_en  = (r_state == S_FETCH);
    acc_rd_idx = (r_state == S_FETCH) ? r_k : 3'd0;
    cent_wr    = (r_state == S_WRITE);
    busy       = (r_state != S_IDLE);
    done       = (r_state == S_DONE);
  end

  // Dividend seeding: optional half-divisor bias gives round-half-up
  always_comb begin
    w_dvd_init = '0;
    for (int i = 0; i < COORD_NUM; i++) begin
`ifdef CENT_UPDATE_ROUND_EN
      w_dvd_init[i] = {1'b0, acc_data[i*ACCUM_CORD_WIDTH +: ACCUM_CORD_WIDTH]}
                    + {{(DVD_W-COUNT_WIDTH){1'b0}}, (acc_count >> 1)};
`else
      w_dvd_init[i] = {1'b0, acc_data[i*ACCUM_CORD_WIDTH +: ACCUM_CORD_WIDTH]};
`endif
    end
  end

  // One restoring-division step per coordinate, plus saturation of the
  // completed quotient (valid on the final DIV cycle)
  always_comb begin
    w_trial   = '0;
    w_rem_nxt = '0;
    w_quo_nxt = '0;
    w_dvd_sh  = '0;
    w_sat     = '0;
    for (int i = 0; i < COORD_NUM; i++) begin
      w_trial[i]  = {r_rem[i], r_dvd[i][DVD_W-1]};
      w_dvd_sh[i] = {r_dvd[i][DVD_W-2:0], 1'b0};
      if (w_trial[i] >= {1'b0, r_count}) begin
        w_rem_nxt[i] = COUNT_WIDTH'(w_trial[i] - {1'b0, r_count});
        w_quo_nxt[i] = {r_quo[i], 1'b1};
      end else begin
        w_rem_nxt[i] = w_trial[i][COUNT_WIDTH-1:0];
        w_quo_nxt[i] = {r_quo[i], 1'b0};
      end
      w_sat[i*CORD_WIDTH +: CORD_WIDTH] = (w_quo_nxt[i] > SAT_MAX)
        ? SAT_MAX[CORD_WIDTH-1:0] : w_quo_nxt[i][CORD_WIDTH-1:0];
    end
  end

  // Datapath: operand latch, divider iteration, result register, index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_k       <= 3'd0;
      r_div_cnt <= 5'd0;
      r_count   <= '0;
      r_old     <= '0;
      r_new     <= '0;
      r_cnt     <= 3'd0;
      r_dvd     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_count   <= acc_count;
          r_old     <= old_centroid;
          r_dvd     <= w_dvd_init;
          r_rem     <= '0;
          r_quo     <= '0;
          r_div_cnt <= DIV_LAST;
        end
        S_DIV: begin
          r_div_cnt <= r_div_cnt - 5'd1;
          r_dvd     <= w_dvd_sh;
          r_rem     <= w_rem_nxt;
          for (int i = 0; i < COORD_NUM; i++)
            r_quo[i] <= w_quo_nxt[i][DVD_W-2:0];
          if (r_div_cnt == 5'd0) begin
            r_cnt <= r_k;
            r_new <= (r_count == '0) ? r_old : w_sat;
          end
        end
        S_WRITE: r_k <= (r_k == LAST_K) ? 3'd0 : r_k + 3'd1;
        default: ;
      endcase
    end
  end

  assign new_centroid = r_new;
  assign cent_cnt     = r_cnt;

endmodule

// File: tb/tb_centroid_update_block.sv
// Bench for centroid_update_block: directed accumulator contents with
// hand-computed quotients; a monitor checks every cent_wr / done against a
// scoreboard queue filled when each pass is launched.

module tb_centroid_update_block;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         acc_rd_en;
  logic [2:0]   acc_rd_idx;
  logic [153:0] acc_data;
  logic [9:0]   acc_count;
  logic [90:0]  old_centroid;
  logic [90:0]  new_centroid;
  logic [2:0]   cent_cnt;
  logic         cent_wr;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  centroid_update_block dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .acc_rd_en    (acc_rd_en),
    .acc_rd_idx   (acc_rd_idx),
    .acc_data     (acc_data),
    .acc_count    (acc_count),
    .old_centroid (old_centroid),
    .new_centroid (new_centroid),
    .cent_cnt     (cent_cnt),
    .cent_wr      (cent_wr),
    .busy         (busy),
    .done         (done)
  );

  // accumulator / pipe1 storage model
  logic [21:0] sum_t [8][7];
  logic [9:0]  cnt_t [8];
  logic [90:0] old_t [8];
  logic [12:0] exp_t [8][7];
  logic [2:0]  rd_q = 3'd0;

  always @(posedge clk) if (acc_rd_en) rd_q <= acc_rd_idx;

  always_comb begin
    acc_data = '0;
    for (int i = 0; i < 7; i++) acc_data[i*22 +: 22] = sum_t[rd_q][i];
  end
  assign acc_count    = cnt_t[rd_q];
  assign old_centroid = old_t[rd_q];

  // cycle bookkeeping: rel() is the spec cycle number (FETCH of k=0 is 1)
  int edge_cnt = 0;
  int start_edge = 0;
  always @(posedge clk) edge_cnt++;
  function automatic int rel();
    return edge_cnt - start_edge + 1;
  endfunction

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [90:0] act, input logic [90:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, rel());
    end
  endtask

  typedef struct {
    int          cyc;
    logic [2:0]  idx;
    logic [90:0] data;
  } wr_t;
  wr_t wr_q[$];
  int  done_q[$];
  wr_t e;
  int  dc;

  function automatic logic [90:0] exp_word(input int k);
    logic [90:0] w;
    w = '0;
    for (int i = 0; i < 7; i++) w[i*13 +: 13] = exp_t[k][i];
    return (cnt_t[k] == 10'd0) ? old_t[k] : w;
  endfunction

  // monitor
  always @(negedge clk) begin
    if (cent_wr === 1'b1) begin
      if (wr_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_cent_wr: got write of cent_cnt=%0d at cycle %0d, expected none", cent_cnt, rel());
      end else begin
        e = wr_q.pop_front();
        check("wr_cycle", 91'(rel()), 91'(e.cyc));
        check("wr_idx", 91'(cent_cnt), 91'(e.idx));
        check("wr_data", new_centroid, e.data);
      end
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", rel());
      end else begin
        dc = done_q.pop_front();
        check("done_cycle", 91'(rel()), 91'(dc));
      end
    end
  end

  task automatic wait_to(input int n);
    while (rel() < n) @(negedge clk);
  endtask

  task automatic begin_pass();
    start = 1'b1;
    start_edge = edge_cnt + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_writes(input int nwr, input bit with_done);
    for (int k = 0; k < nwr; k++) begin
      wr_t w;
      w.cyc  = 26 + 26 * k;
      w.idx  = 3'(k);
      w.data = exp_word(k);
      wr_q.push_back(w);
    end
    if (with_done) done_q.push_back(209);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_acc_rd_en"}, 91'(acc_rd_en), 91'(0));
    check({tag, "_acc_rd_idx"}, 91'(acc_rd_idx), 91'(0));
    check({tag, "_new_centroid"}, new_centroid, 91'(0));
    check({tag, "_cent_cnt"}, 91'(cent_cnt), 91'(0));
    check({tag, "_cent_wr"}, 91'(cent_wr), 91'(0));
    check({tag, "_busy"}, 91'(busy), 91'(0));
    check({tag, "_done"}, 91'(done), 91'(0));
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      cnt_t[k] = 10'd0;
      old_t[k] = '0;
      for (int i = 0; i < 7; i++) begin
        sum_t[k][i] = 22'd0;
        exp_t[k][i] = 13'd0;
      end
    end
    cnt_t[0] = 10'd3;    sum_t[0][0] = 22'd1000;    exp_t[0][0] = 13'd333;
    cnt_t[1] = 10'd2;    sum_t[1][0] = 22'd1001;    sum_t[1][3] = 22'd7;
    cnt_t[2] = 10'd1;    sum_t[2][0] = 22'h3FFFFF;  sum_t[2][2] = 22'd8192;
    sum_t[2][6] = 22'd8191;
    exp_t[2][0] = 13'd8191; exp_t[2][2] = 13'd8191; exp_t[2][6] = 13'd8191;
    cnt_t[3] = 10'd1023; sum_t[3][0] = 22'd4092000; sum_t[3][1] = 22'd4092600;
    exp_t[3][0] = 13'd4000;
    cnt_t[4] = 10'd0;    sum_t[4][0] = 22'd500;     old_t[4] = 91'h123;
    cnt_t[5] = 10'd10;   sum_t[5][0] = 22'd12345;   sum_t[5][4] = 22'd99;
    cnt_t[6] = 10'd0;    sum_t[6][1] = 22'd77;      old_t[6] = {7{13'h1555}};
    cnt_t[7] = 10'd7;    sum_t[7][5] = 22'd70;      sum_t[7][6] = 22'd13;
    exp_t[7][5] = 13'd10;
`ifdef CENT_UPDATE_ROUND_EN
    exp_t[1][0] = 13'd501; exp_t[1][3] = 13'd4;
    exp_t[3][1] = 13'd4001;
    exp_t[5][0] = 13'd1235; exp_t[5][4] = 13'd10;
    exp_t[7][6] = 13'd2;
`else
    exp_t[1][0] = 13'd500; exp_t[1][3] = 13'd3;
    exp_t[3][1] = 13'd4000;
    exp_t[5][0] = 13'd1234; exp_t[5][4] = 13'd9;
    exp_t[7][6] = 13'd1;
`endif

    // reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // pass 1: full pass, stray start mid-pass and in DONE
    push_writes(8, 1'b1);
    begin_pass();
    check("p1_busy_c1", 91'(busy), 91'(1));
    check("p1_rd_en_c1", 91'(acc_rd_en), 91'(1));
    check("p1_rd_idx_c1", 91'(acc_rd_idx), 91'(0));
    wait_to(40);
    check("p1_hold_data", new_centroid, exp_word(0));
    wait_to(100);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_to(209);
    check("p1_busy_done", 91'(busy), 91'(1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("p1_busy_c210", 91'(busy), 91'(0));
    wait_to(240);
    check("p1_busy_after", 91'(busy), 91'(0));
    check("p1_writes_left", 91'(wr_q.size()), 91'(0));
    check("p1_done_left", 91'(done_q.size()), 91'(0));

    // pass 2: reset in cycle 60 aborts
    push_writes(2, 1'b0);
    begin_pass();
    wait_to(60);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("p2_writes_left", 91'(wr_q.size()), 91'(0));
    check("p2_busy_after", 91'(busy), 91'(0));

    // pass 3: fresh pass after reset starts from index 0
    push_writes(8, 1'b1);
    begin_pass();
    check("p3_rd_idx_c1", 91'(acc_rd_idx), 91'(0));
    wait_to(215);
    check("p3_writes_left", 91'(wr_q.size()), 91'(0));
    check("p3_done_left", 91'(done_q.size()), 91'(0));
    check("p3_busy_after", 91'(busy), 91'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/centroid_update_block.md
# centroid_update_block

Recomputes the K centroids at the end of each k-means iteration. After the accumulation pass, it reads the per-centroid coordinate sums and point counts one centroid at a time and divides each coordinate sum by the count. It then writes each new centroid to the classification pipe1 centroid registers over the new_centroid / cent_cnt interface, so it is the writer for the port pipe1 reads. A zero-count (empty) centroid keeps its previous value.

## Interface
- accum_width, 7*22, packed coordinate sums for one centroid
- dataWidth, 91, packed centroid (7 coordinates x 13 bits)
- centroid_num, 8, number of centroids updated per pass
- accum_cord_width, 22, width of one coordinate sum
- cordinate_width, 13, width of one centroid coordinate
- count_width, 10, width of the point count

Ports:
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse from controller; begins an update pass
- acc_rd_en  out  1  read strobe to accumulator storage
- acc_rd_idx  out  3  centroid index being read
- acc_data  in  accum_width  coordinate sums; coordinate i at [22i+21:22i]; valid one cycle after acc_rd_en
- acc_count  in  count_width  point count; same timing as acc_data
- old_centroid  in  dataWidth  current centroid acc_rd_idx from pipe1; same timing as acc_data
- new_centroid  out  dataWidth  updated centroid; coordinate i at [13i+12:13i]
- cent_cnt  out  3  index of the centroid on new_centroid
- cent_wr  out  1  write strobe to pipe1 for new_centroid / cent_cnt
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when the pass is complete

## Operation
- FSM states: IDLE, FETCH, LOAD, DIV, WRITE, DONE.
- IDLE -> FETCH when start=1. A start pulse while busy=1 is ignored.
- FETCH (1 cycle): acc_rd_en=1, acc_rd_idx=k.
- LOAD (1 cycle): latch acc_data, acc_count and old_centroid. Set dividend_i = acc_data[i] zero-extended to 23 bits, plus the rounding term (see Configuration).
- DIV (23 cycles): seven parallel restoring dividers, one quotient bit per cycle, MSB first, each with a 23-bit dividend and 10-bit divisor.
- WRITE (1 cycle):
  - cent_wr=1 and cent_cnt=k.
  - If count≠0, new_centroid coordinate i = quotient_i, saturated to 8191 if quotient_i > 8191.
  - If count=0, new_centroid = latched old_centroid.
  - Then k<centroid_num-1 -> k+1, FETCH; otherwise -> DONE.
- DONE (1 cycle): done=1, then IDLE.
- All arithmetic is unsigned.
- The zero-count case still runs the full DIV duration, so latency is fixed.

## Timing
- Reset: on a clk edge with rst_n=0, the FSM goes to IDLE and k=0. The following outputs read 0: acc_rd_en, acc_rd_idx, new_centroid, cent_cnt, cent_wr, busy, done.
- Reset mid-pass aborts the pass and produces no further cent_wr. Centroids already written stay written.
- Cycle numbering: start is sampled at edge 0.
  - FETCH is cycle 1, LOAD is cycle 2, DIV is cycles 3-25, WRITE is cycle 26.
  - Each centroid takes 26 cycles; WRITE for centroid k is in cycle 26+26k.
  - DONE is in cycle 26*centroid_num+1 (209 for 8 centroids).
- new_centroid and cent_cnt are registered and change only on entry to WRITE. They hold between writes. cent_wr is high for exactly one cycle per centroid.
- busy=1 from cycle 1 through the DONE cycle inclusive.
- start arriving in the DONE cycle is ignored; the next pass requires start while in IDLE.

## Configuration
- CENT_UPDATE_ROUND_EN defined: dividend = sum + (count>>1), giving round-half-up to nearest.
- CENT_UPDATE_ROUND_EN undefined: dividend = sum, giving truncation.
- Both builds use identical cycle timing and ports.

## Test plan
- Centroid 0: sum coordinate 0=1000, count=3. Truncation build -> coordinate 0=333; round build -> 333 (1001/3). Sum=1001, count=2 -> truncation 500, round 501.
- Centroid 4: count=0, old_centroid=91'h123. WRITE in cycle 130 carries cent_cnt=4, new_centroid=91'h123.
- Sum=22'h3FFFFF, count=1 -> coordinate saturates to 8191.
- Full pass: exactly 8 cent_wr pulses, in cycles 26, 52, ..., 208, with cent_cnt 0..7. done in cycle 209; busy low in cycle 210.
- Pulse start again in cycle 100 of a pass -> no effect; still 8 writes, single done.
- Drive rst_n=0 in cycle 60 -> all outputs 0 next cycle, no cent_wr afterwards. A new start after reset runs a full pass from index 0.
